uart_tx_arbiter: RTL and testbench

Shares the single `uart_tx` transmitter between `NREQ` byte-stream requesters (e.g. RX echo path, status reporter, ID banner) so they cannot interleave on `serial_tx`. Arbitration is round-robin and message-granular: a granted requester keeps the transmitter until it hands over a byte flagged `last`, or until it stalls past a gap timeout. The block sits between the requesters and `uart_tx`'s `tx_data/tx_valid/tx_ready` handshake. It exposes grant and statistics outputs for the HEX/LED debug display.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the UART transmit-side arbitration slice.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    localparam int BYTE_W  = 8;
    localparam int GRANT_W = 3;

    // Circular index base+k reduced modulo n. Callers keep base < n and
    // 1 <= k <= n, so a single conditional subtract is enough.
    function automatic int rr_index(input int base, input int k, input int n);
        int s;
        s = base + k;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Purpose: combinational round-robin selector, scans circularly from last_grant+1.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is taken.
//
// Ports:
//   req        in  NREQ     request vector
//   last_grant in  GRANT_W  most recently finished requester (lowest priority)
//   any        out 1        at least one request is set
//   pick_idx   out GRANT_W  winning requester, zero-extended; 0 when !any
module rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]    req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic               any,
    output logic [GRANT_W-1:0] pick_idx
);

    // Walk the circular distance from the farthest candidate (k = NREQ, which is
    // last_grant itself) down to the nearest (k = 1). The last assignment made
    // is the nearest requesting index, so no early exit is needed.
    always_comb begin
        any      = 1'b0;
        pick_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && (i == rr_index(int'(last_grant), k, NREQ))) begin
                    any      = 1'b1;
                    pick_idx = GRANT_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one uart_tx between NREQ byte streams, round-robin per message.
// Latency: request to grant 1 cycle; granted bytes pass through combinationally.
// Backpressure: tx_ready flows straight back to the granted req_ready; others wait.
//
// Ports:
//   clk, rst               CLOCK_50 domain, synchronous active-high reset
//   req_valid/data/last    per-requester byte stream (data at [i*8 +: 8])
//   req_ready              byte of requester i accepted this cycle
//   tx_data/valid/ready    handshake towards uart_tx
//   busy, grant_id         grant held / current or most recent grant index
//   sent_count             bytes accepted by uart_tx, wraps modulo 2^16
//   abort_count            grants revoked by gap timeout, saturates at 255
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int GAP_MAX = 50_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [BYTE_W*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic [BYTE_W-1:0]        tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic [GRANT_W-1:0]       grant_id,
    output logic [15:0]              sent_count,
    output logic [7:0]               abort_count
);

    localparam int GAP_W = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MAX - 1);

    arb_state_t          state_q;
    arb_state_t          state_d;
    logic [GRANT_W-1:0]  grant_q;
    logic [GRANT_W-1:0]  last_grant_q;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic [15:0]         sent_q;
    logic [7:0]          abort_q;

    logic                sel_vld;
    logic                sel_last;
    logic [BYTE_W-1:0]   sel_dat;
    logic                pick_any;
    logic [GRANT_W-1:0]  pick_idx;
    logic                in_busy;
    logic                accept;
    logic                gap_tick;
    logic                timeout;
    logic                done;

    rr_pick #(
        .NREQ       (NREQ)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .any        (pick_any),
        .pick_idx   (pick_idx)
    );

    // Mux out the granted requester's lane.
    always_comb begin
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_dat  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == GRANT_W'(i)) begin
                sel_vld  = req_valid[i];
                sel_last = req_last[i];
                sel_dat  = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign in_busy  = (state_q == BUSY);
    assign accept   = in_busy && sel_vld && tx_ready;
    // The gap only counts while the requester has nothing to offer; a byte
    // waiting on a busy uart_tx is not a stall of the requester.
    assign gap_tick = in_busy && !sel_vld;
    assign timeout  = gap_tick && (gap_cnt_q == GAP_LAST);
    assign done     = (accept && sel_last) || timeout;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = BUSY;
            BUSY:    if (done)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = in_busy;
        tx_valid  = in_busy && sel_vld;
        tx_data   = in_busy ? sel_dat : '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = in_busy && (grant_q == GRANT_W'(i))
                           && req_valid[i] && tx_ready;
        end
    end

    // ---------------- grant, gap timer and statistics ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q      <= '0;
            last_grant_q <= GRANT_W'(NREQ - 1);
            gap_cnt_q    <= '0;
            sent_q       <= '0;
            abort_q      <= '0;
        end else begin
            if ((state_q == IDLE) && pick_any) begin
                grant_q   <= pick_idx;
                gap_cnt_q <= '0;
            end

            if (accept) begin
                sent_q    <= sent_q + 16'd1;
                gap_cnt_q <= '0;
            end else if (timeout) begin
                gap_cnt_q <= '0;
            end else if (gap_tick) begin
                gap_cnt_q <= gap_cnt_q + 1'b1;
            end

            // The finishing requester becomes lowest priority for the next pick.
            if (done) begin
                last_grant_q <= grant_q;
            end

            if (timeout && (abort_q != 8'hFF)) begin
                abort_q <= abort_q + 8'd1;
            end
        end
    end

    assign grant_id    = grant_q;
    assign sent_count  = sent_q;
    assign abort_count = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: directed, table-driven bench for uart_tx_arbiter (NREQ=3, GAP_MAX=16).
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: tx_ready driven directly by the bench.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [2:0]  grant_id;
    logic [15:0] sent_count;
    logic [7:0]  abort_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ        (3),
        .GAP_MAX     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .grant_id    (grant_id),
        .sent_count  (sent_count),
        .abort_count (abort_count)
    );

    typedef struct {
        logic [2:0]  rv;
        logic [23:0] rd;
        logic [2:0]  rl;
        logic        tr;
        logic        e_busy;
        logic        e_tv;
        logic [7:0]  e_td;
        logic [2:0]  e_rr;
        logic [2:0]  e_gid;
        logic [15:0] e_sent;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " busy"},        32'(busy),        32'd0);
        chk({tag, " tx_valid"},    32'(tx_valid),    32'd0);
        chk({tag, " req_ready"},   32'(req_ready),   32'd0);
        chk({tag, " grant_id"},    32'(grant_id),    32'd0);
        chk({tag, " sent_count"},  32'(sent_count),  32'd0);
        chk({tag, " abort_count"}, 32'(abort_count), 32'd0);
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        rst       = 1'b1;
        next_cycle();
        @(negedge clk);
        check_reset_vals("reset");
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            req_valid = vecs[i].rv;
            req_data  = vecs[i].rd;
            req_last  = vecs[i].rl;
            tx_ready  = vecs[i].tr;
            @(negedge clk);
            chk($sformatf("vec%0d busy", i),      32'(busy),       32'(vecs[i].e_busy));
            chk($sformatf("vec%0d tx_valid", i),  32'(tx_valid),   32'(vecs[i].e_tv));
            chk($sformatf("vec%0d req_ready", i), 32'(req_ready),  32'(vecs[i].e_rr));
            chk($sformatf("vec%0d grant_id", i),  32'(grant_id),   32'(vecs[i].e_gid));
            chk($sformatf("vec%0d sent", i),      32'(sent_count), 32'(vecs[i].e_sent));
            if (vecs[i].e_tv) begin
                chk($sformatf("vec%0d tx_data", i), 32'(tx_data), 32'(vecs[i].e_td));
            end
            next_cycle();
        end
    endtask

    logic [2:0] order[$];
    logic       r2_done;
    int         bad_cnt;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;

        //               rv      rd          rl      tr    busy  tv    td     rr      gid   sent
        // single byte from requester 1 after reset
        vecs[0]  = '{3'b010, 24'h004100, 3'b010, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 3'd0, 16'd0};
        vecs[1]  = '{3'b010, 24'h004100, 3'b010, 1'b1, 1'b1, 1'b1, 8'h41, 3'b010, 3'd1, 16'd0};
        vecs[2]  = '{3'b000, 24'h000000, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 3'd1, 16'd1};
        // three 2-byte messages in contention, one dead cycle between each
        vecs[3]  = '{3'b111, 24'h302010, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 3'd0, 16'd0};
        vecs[4]  = '{3'b111, 24'h302010, 3'b000, 1'b1, 1'b1, 1'b1, 8'h10, 3'b001, 3'd0, 16'd0};
        vecs[5]  = '{3'b111, 24'h302011, 3'b001, 1'b1, 1'b1, 1'b1, 8'h11, 3'b001, 3'd0, 16'd1};
        vecs[6]  = '{3'b110, 24'h302000, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 3'd0, 16'd2};
        vecs[7]  = '{3'b110, 24'h302000, 3'b000, 1'b1, 1'b1, 1'b1, 8'h20, 3'b010, 3'd1, 16'd2};
        vecs[8]  = '{3'b110, 24'h302100, 3'b010, 1'b1, 1'b1, 1'b1, 8'h21, 3'b010, 3'd1, 16'd3};
        vecs[9]  = '{3'b100, 24'h300000, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 3'd1, 16'd4};
        vecs[10] = '{3'b100, 24'h300000, 3'b000, 1'b1, 1'b1, 1'b1, 8'h30, 3'b100, 3'd2, 16'd4};
        vecs[11] = '{3'b100, 24'h310000, 3'b100, 1'b1, 1'b1, 1'b1, 8'h31, 3'b100, 3'd2, 16'd5};
        vecs[12] = '{3'b000, 24'h000000, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 3'd2, 16'd6};

        do_reset();
        run_vectors(0, 2);
        do_reset();
        run_vectors(3, 12);

        // Round-robin: requester 0 always busy, requester 2 asks once.
        do_reset();
        req_data  = 24'h3000A0;
        req_last  = 3'b101;
        req_valid = 3'b101;
        tx_ready  = 1'b1;
        r2_done   = 1'b0;
        order.delete();
        for (int c = 0; c < 20 && order.size() < 3; c++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) order.push_back(grant_id);
            if (req_ready[2]) r2_done = 1'b1;
            next_cycle();
            if (r2_done) req_valid[2] = 1'b0;
        end
        chk("rr grant count", 32'(order.size()), 32'd3);
        if (order.size() >= 3) begin
            chk("rr grant 1st", 32'(order[0]), 32'd0);
            chk("rr grant 2nd", 32'(order[1]), 32'd2);
            chk("rr grant 3rd", 32'(order[2]), 32'd0);
        end

        // Backpressure: 5000 cycles of tx_ready low must not trip the gap timer.
        do_reset();
        req_valid = 3'b001;
        req_data  = 24'h0000A5;
        req_last  = 3'b000;
        tx_ready  = 1'b0;
        next_cycle();
        bad_cnt = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (!(busy && tx_valid && tx_data == 8'hA5 && req_ready == 3'b000)) bad_cnt++;
            next_cycle();
        end
        chk("bp held stable", 32'(bad_cnt), 32'd0);
        chk("bp abort during", 32'(abort_count), 32'd0);
        tx_ready = 1'b1;
        @(negedge clk);
        chk("bp accept ready", 32'(req_ready), 32'b001);
        chk("bp accept data", 32'(tx_data), 32'hA5);
        next_cycle();
        req_data = 24'h0000A6;
        req_last = 3'b001;
        @(negedge clk);
        chk("bp last data", 32'(tx_data), 32'hA6);
        next_cycle();
        req_valid = 3'b000;
        @(negedge clk);
        chk("bp idle after", 32'(busy), 32'd0);
        chk("bp abort after", 32'(abort_count), 32'd0);
        chk("bp sent", 32'(sent_count), 32'd2);

        // Timeout: requester 0 stalls after one byte, requester 1 is pending.
        do_reset();
        req_valid = 3'b011;
        req_data  = 24'h006655;
        req_last  = 3'b010;
        tx_ready  = 1'b1;
        next_cycle();                       // cycle 0: IDLE, picks requester 0
        @(negedge clk);                     // cycle 1: byte 0x55 accepted
        chk("to first data", 32'(tx_data), 32'h55);
        chk("to first ready", 32'(req_ready), 32'b001);
        next_cycle();
        req_valid = 3'b010;
        repeat (15) next_cycle();           // cycles 2..16: gap 0..14 -> 1..15
        @(negedge clk);                     // cycle 17: 16th idle cycle, timeout due
        chk("to still busy", 32'(busy), 32'd1);
        chk("to abort before", 32'(abort_count), 32'd0);
        chk("to r1 waiting", 32'(req_ready), 32'b000);
        next_cycle();
        @(negedge clk);                     // cycle 18
        chk("to idle", 32'(busy), 32'd0);
        chk("to abort", 32'(abort_count), 32'd1);
        next_cycle();
        @(negedge clk);                     // cycle 19
        chk("to regrant busy", 32'(busy), 32'd1);
        chk("to regrant id", 32'(grant_id), 32'd1);
        chk("to regrant data", 32'(tx_data), 32'h66);

        // Reset in the middle of a 3-byte message from requester 2.
        do_reset();
        req_valid = 3'b100;
        req_data  = 24'hC10000;
        req_last  = 3'b000;
        tx_ready  = 1'b1;
        next_cycle();                       // cycle 0: IDLE
        next_cycle();                       // cycle 1: 0xC1 accepted
        req_data = 24'hC20000;
        @(negedge clk);
        chk("mid sent before rst", 32'(sent_count), 32'd1);
        chk("mid grant before rst", 32'(grant_id), 32'd2);
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        check_reset_vals("mid reset");
        rst       = 1'b0;
        req_valid = 3'b000;
        next_cycle();

        // sent_count wrap: stream 65536 bytes as a single message.
        do_reset();
        req_valid = 3'b001;
        req_data  = 24'h000077;
        req_last  = 3'b000;
        tx_ready  = 1'b1;
        next_cycle();                       // cycle 0: IDLE
        repeat (65535) next_cycle();        // cycles 1..65535 each accept
        @(negedge clk);
        chk("wrap ffff", 32'(sent_count), 32'hFFFF);
        next_cycle();
        @(negedge clk);
        chk("wrap zero", 32'(sent_count), 32'h0000);
        chk("wrap busy", 32'(busy), 32'd1);
        chk("wrap abort", 32'(abort_count), 32'd0);
        req_valid = 3'b000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
